inst_rom_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 6 +
 rtl/byte_packer.sv | 42 ++++
 rtl/inst_rom_loader.sv | 85 ++++++++
 tb/tb_inst_rom_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction ROM loader.
package loader_pkg;
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;
   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_packer.sv
// Packs bytes MSB-first into a registered 32-bit word; word_valid pulses one cycle
// after the edge that accepts the fourth byte. fill flags that completing byte.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        fill,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [1:0]  idx;
   logic [23:0] shreg;

   assign fill = in_valid && !clr && (idx == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         shreg      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= fill;
         if (clr) begin
            idx   <= '0;
            shreg <= '0;
         end else if (in_valid) begin
            if (fill) begin
               word <= {shreg, in_byte};
               idx  <= '0;
            end else begin
               shreg <= {shreg[15:0], in_byte};
               idx   <= idx + 2'd1;
            end
         end
      end
   end
endmodule

// File: rtl/inst_rom_loader.sv
// Parses a 16-bit word-count header, then writes packed big-endian words to
// consecutive addresses from 0 while holding the CPU in reset until the last write.
module inst_rom_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              rom_we_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic [31:0]       rom_data_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   state_t      state, nxt;
   logic [7:0]  cnt_hi;
   logic [15:0] count;
   logic [16:0] wcnt;
   logic [15:0] hdr;
   logic        take;
   logic        fill;
   logic        word_valid;
   logic [31:0] word;

   assign byte_ready_o = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
   assign take         = byte_valid_i && byte_ready_o;
   assign hdr          = {cnt_hi, byte_i};
   assign cpu_rst_o    = (state != DONE);
   assign done_o       = (state == DONE);
   assign err_o        = (state == ERR);
   assign rom_we_o     = word_valid;
   assign rom_data_o   = word;

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (state != DATA),
      .in_byte    (byte_i),
      .in_valid   (take && (state == DATA)),
      .fill       (fill),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HDR_HI;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         HDR_HI: if (take) nxt = HDR_LO;
         HDR_LO: if (take) begin
            if (hdr == 16'd0)                nxt = DONE;
            else if ({1'b0, hdr} > 17'(DEPTH)) nxt = ERR;
            else                             nxt = DATA;
         end
         // Leave DATA as the final write strobe ends, so memory is settled first.
         DATA:   if (word_valid && (wcnt + 17'd1 == {1'b0, count})) nxt = DONE;
         default: nxt = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_hi     <= '0;
         count      <= '0;
         wcnt       <= '0;
         rom_addr_o <= '0;
      end else begin
         if (take && state == HDR_HI) cnt_hi <= byte_i;
         if (take && state == HDR_LO) count  <= hdr;
         if (fill)       rom_addr_o <= wcnt[ADDR_W-1:0];
         if (word_valid) wcnt       <= wcnt + 17'd1;
      end
   end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: per-cycle vector table plus multi-cycle sequences.
module tb_inst_rom_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  byte_i = 8'h00;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o, rom_we_o, cpu_rst_o, done_o, err_o;
   logic [9:0]  rom_addr_o;
   logic [31:0] rom_data_o;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      logic [7:0]  b;
      logic        v;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] data;
      logic        rdy;
      logic        done;
      logic        crst;
   } vec_t;
   vec_t tbl[12];

   inst_rom_loader #(.ADDR_W(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .rom_we_o     (rom_we_o),
      .rom_addr_o   (rom_addr_o),
      .rom_data_o   (rom_data_o),
      .cpu_rst_o    (cpu_rst_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   // Each write strobe spans exactly one full cycle, so one negedge sample per write.
   always @(negedge clk) begin
      if (rom_we_o) wq.push_back('{addr: rom_addr_o, data: rom_data_o});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      byte_valid_i = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wq.delete();
   endtask

   // Drive one accepted byte after `gap` idle cycles carrying junk with valid low.
   task automatic send(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         byte_valid_i = 1'b0;
         byte_i = 8'($urandom);
         @(negedge clk);
      end
      byte_valid_i = 1'b1;
      byte_i = b;
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      send(w[31:24], $urandom_range(0, maxgap));
      send(w[23:16], $urandom_range(0, maxgap));
      send(w[15:8],  $urandom_range(0, maxgap));
      send(w[7:0],   $urandom_range(0, maxgap));
   endtask

   function automatic vec_t mk(input logic [7:0] b, input logic v, input logic we,
                               input logic [9:0] a, input logic [31:0] d,
                               input logic rdy, input logic dn, input logic cr);
      vec_t t;
      t.b = b; t.v = v; t.we = we; t.addr = a; t.data = d;
      t.rdy = rdy; t.done = dn; t.crst = cr;
      return t;
   endfunction

   initial begin
      int errs;
      logic [31:0] w;

      tbl[0]  = mk(8'h00, 1, 0, 10'd0, 32'h0,        1, 0, 1);
      tbl[1]  = mk(8'h02, 1, 0, 10'd0, 32'h0,        1, 0, 1);
      tbl[2]  = mk(8'h34, 1, 0, 10'd0, 32'h0,        1, 0, 1);
      tbl[3]  = mk(8'h01, 1, 0, 10'd0, 32'h0,        1, 0, 1);
      tbl[4]  = mk(8'h11, 1, 0, 10'd0, 32'h0,        1, 0, 1);
      tbl[5]  = mk(8'h00, 1, 1, 10'd0, 32'h34011100, 1, 0, 1);
      tbl[6]  = mk(8'h34, 1, 0, 10'd0, 32'h34011100, 1, 0, 1);
      tbl[7]  = mk(8'h02, 1, 0, 10'd0, 32'h34011100, 1, 0, 1);
      tbl[8]  = mk(8'h00, 1, 0, 10'd0, 32'h34011100, 1, 0, 1);
      tbl[9]  = mk(8'h20, 1, 1, 10'd1, 32'h34020020, 1, 0, 1);
      tbl[10] = mk(8'hEE, 0, 0, 10'd1, 32'h34020020, 0, 1, 0);
      tbl[11] = mk(8'hFF, 1, 0, 10'd1, 32'h34020020, 0, 1, 0);

      // Reset values while rst is held low.
      #2;
      chk("rst_ready", 32'(byte_ready_o), 32'd1);
      chk("rst_we",    32'(rom_we_o),     32'd0);
      chk("rst_addr",  32'(rom_addr_o),   32'd0);
      chk("rst_data",  rom_data_o,        32'd0);
      chk("rst_cpu",   32'(cpu_rst_o),    32'd1);
      chk("rst_done",  32'(done_o),       32'd0);
      chk("rst_err",   32'(err_o),        32'd0);

      // Back-to-back load, checked cycle by cycle.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         byte_i = tbl[i].b;
         byte_valid_i = tbl[i].v;
         @(negedge clk);
         chk($sformatf("tbl%0d_we", i),   32'(rom_we_o),     32'(tbl[i].we));
         chk($sformatf("tbl%0d_addr", i), 32'(rom_addr_o),   32'(tbl[i].addr));
         chk($sformatf("tbl%0d_data", i), rom_data_o,        tbl[i].data);
         chk($sformatf("tbl%0d_rdy", i),  32'(byte_ready_o), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_done", i), 32'(done_o),       32'(tbl[i].done));
         chk($sformatf("tbl%0d_crst", i), 32'(cpu_rst_o),    32'(tbl[i].crst));
      end
      byte_valid_i = 1'b0;

      // Same stream with random gaps and junk bytes while valid is low.
      do_reset();
      send(8'h00, 2); send(8'h02, 1);
      send_word(32'h34011100, 3);
      send_word(32'h34020020, 3);
      repeat (2) @(negedge clk);
      chk("gap_nwr", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         chk("gap_a0", 32'(wq[0].addr), 32'd0);
         chk("gap_d0", wq[0].data,      32'h34011100);
         chk("gap_a1", 32'(wq[1].addr), 32'd1);
         chk("gap_d1", wq[1].data,      32'h34020020);
      end
      chk("gap_done", 32'(done_o),    32'd1);
      chk("gap_crst", 32'(cpu_rst_o), 32'd0);

      // After DONE, eight more valid bytes change nothing.
      for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 0);
      @(negedge clk);
      chk("post_nwr",  32'(wq.size()), 32'd2);
      chk("post_done", 32'(done_o),    32'd1);
      chk("post_crst", 32'(cpu_rst_o), 32'd0);

      // Zero-count header.
      do_reset();
      send(8'h00, 0);
      chk("z_mid_done", 32'(done_o), 32'd0);
      send(8'h00, 0);
      chk("z_done", 32'(done_o),    32'd1);
      chk("z_crst", 32'(cpu_rst_o), 32'd0);
      repeat (3) @(negedge clk);
      chk("z_nwr", 32'(wq.size()), 32'd0);

      // Oversized header: one past DEPTH.
      do_reset();
      send(8'h04, 0); send(8'h01, 0);
      chk("e_err",  32'(err_o),        32'd1);
      chk("e_rdy",  32'(byte_ready_o), 32'd0);
      chk("e_crst", 32'(cpu_rst_o),    32'd1);
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 0);
      chk("e_nwr",   32'(wq.size()), 32'd0);
      chk("e_err2",  32'(err_o),     32'd1);
      chk("e_crst2", 32'(cpu_rst_o), 32'd1);
      chk("e_done",  32'(done_o),    32'd0);

      // Full-depth load: 1024 words, last at 0x3FF.
      do_reset();
      send(8'h04, 0); send(8'h00, 0);
      for (int i = 0; i < 1024; i++) begin
         w = 32'h5A00_0000 ^ (i * 32'h0001_0203);
         send_word(w, 0);
         if (i == 1022) chk("full_crst_mid", 32'(cpu_rst_o), 32'd1);
      end
      repeat (2) @(negedge clk);
      chk("full_nwr", 32'(wq.size()), 32'd1024);
      errs = 0;
      for (int i = 0; i < wq.size(); i++) begin
         w = 32'h5A00_0000 ^ (i * 32'h0001_0203);
         if (wq[i].addr !== 10'(i) || wq[i].data !== w) errs++;
      end
      chk("full_content", 32'(errs), 32'd0);
      if (wq.size() == 1024) chk("full_last_addr", 32'(wq[1023].addr), 32'h3FF);
      chk("full_done", 32'(done_o),    32'd1);
      chk("full_crst", 32'(cpu_rst_o), 32'd0);

      // Reset mid-load, then a fresh single-word load.
      do_reset();
      send(8'h00, 0); send(8'h03, 0);
      send_word(32'h11223344, 0);
      send(8'h55, 0); send(8'h66, 0);
      #2 rst = 1'b0;
      #1;
      chk("mr_crst",  32'(cpu_rst_o),    32'd1);
      chk("mr_rdy",   32'(byte_ready_o), 32'd1);
      chk("mr_we",    32'(rom_we_o),     32'd0);
      @(negedge clk);
      rst = 1'b1;
      wq.delete();
      send(8'h00, 0); send(8'h01, 0);
      send_word(32'hAABBCCDD, 0);
      repeat (2) @(negedge clk);
      chk("mr_nwr", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) begin
         chk("mr_addr", 32'(wq[0].addr), 32'd0);
         chk("mr_data", wq[0].data,      32'hAABBCCDD);
      end
      chk("mr_done", 32'(done_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
